quad_step_decoder: RTL and testbench

//  Upstream stage of the 2-bit up/down state machine.
//  - Turns a raw rotary-encoder quadrature pair (a_in, b_in) into a one-cycle step strobe and a held direction level (up).
//  - The counter FSM advances on step, using up as its direction input.
//  - Contains input synchronisation, debouncing and quadrature decoding.

---
 rtl/quad_pkg.sv | 20 ++
 rtl/quad_input_filter.sv | 57 +++++
 rtl/quad_step_decoder.sv | 90 +++++++++
 tb/tb_quad_step_decoder.sv | 150 +++++++++++++++
 4 files changed

// File: rtl/quad_pkg.sv
// Shared definitions for the quadrature step decoder.
//   INIT / TRACK       : FSM state encodings
//   FWD_NEXT / REV_NEXT: next phase pair in forward / reverse Gray order,
//                        indexed by the current pair {a,b}
//   cnt_width()        : width of the debounce stability counter
package quad_pkg;

  localparam logic [0:0] INIT  = 1'b0;
  localparam logic [0:0] TRACK = 1'b1;

  // Forward 00->01->11->10->00, reverse 00->10->11->01->00.
  // Entry [i] is the successor of pair i.
  localparam logic [3:0][1:0] FWD_NEXT = {2'b10, 2'b00, 2'b11, 2'b01};
  localparam logic [3:0][1:0] REV_NEXT = {2'b01, 2'b11, 2'b00, 2'b10};

  function automatic int cnt_width(input int deb);
    return (deb < 1) ? 1 : $clog2(deb + 1);
  endfunction

endpackage

// File: rtl/quad_input_filter.sv
// Two-flop synchroniser plus 2-bit stability filter for the encoder phases.
//   clock, reset : system clock, async active-low reset
//   a_in, b_in   : raw encoder phases (asynchronous)
//   q            : filtered phase pair {a,b}
//   q_upd        : one-clock pulse, q changed on the previous edge
//   settled      : registered "s has been stable long enough"; the top uses
//                  it to leave INIT when the pair never changes from 00
module quad_input_filter
  import quad_pkg::*;
#(
  parameter int DEB_CYCLES = 4
) (
  input  logic       clock,
  input  logic       reset,
  input  logic       a_in,
  input  logic       b_in,
  output logic [1:0] q,
  output logic       q_upd,
  output logic       settled
);

  localparam int CW = cnt_width(DEB_CYCLES);
  localparam logic [CW-1:0] CNT_MAX = CW'(DEB_CYCLES - 1);

  logic [1:0]    sync1, s;
  logic [CW-1:0] cnt;
  logic          stable, ready;

  // Comparing the value about to enter s with s itself detects a change of s
  // one clock earlier than registering s again would, so acceptance lands
  // 2 + DEB_CYCLES clocks after the raw edge with no extra stage.
  assign stable = (sync1 == s);
  assign ready  = stable && (cnt == CNT_MAX);

  always_ff @(posedge clock or negedge reset) begin
    if (!reset) begin
      sync1   <= 2'b00;
      s       <= 2'b00;
      cnt     <= '0;
      q       <= 2'b00;
      q_upd   <= 1'b0;
      settled <= 1'b0;
    end else begin
      sync1   <= {a_in, b_in};
      s       <= sync1;
      q_upd   <= 1'b0;
      settled <= ready;
      if (!stable)            cnt <= '0;
      else if (cnt != CNT_MAX) cnt <= cnt + 1'b1;   // saturate, never wrap
      if (ready && (s != q)) begin
        q     <= s;
        q_upd <= 1'b1;
      end
    end
  end

endmodule

// File: rtl/quad_step_decoder.sv
// Rotary-encoder quadrature decoder feeding the 2-bit up/down counter FSM.
//   clock, reset : system clock, async active-low reset
//   a_in, b_in   : raw encoder phases (asynchronous)
//   step         : one-clock pulse per accepted Gray-order edge
//   up           : direction of the last accepted edge (1 = forward), held
//   err          : one-clock pulse when both phases changed at once
//   err_count    : saturating illegal-edge count (only with QUAD_ERR_CNT_EN)
// Optional feature macro: QUAD_ERR_CNT_EN
module quad_step_decoder
  import quad_pkg::*;
#(
  parameter int DEB_CYCLES = 4,
  parameter int ERR_W      = 8
) (
  input  logic             clock,
  input  logic             reset,
  input  logic             a_in,
  input  logic             b_in,
  output logic             step,
  output logic             up,
`ifdef QUAD_ERR_CNT_EN
  output logic             err,
  output logic [ERR_W-1:0] err_count
`else
  output logic             err
`endif
);

  if (DEB_CYCLES < 1 || ERR_W < 1) begin : g_bad_param
    $error("quad_step_decoder: DEB_CYCLES and ERR_W must be >= 1");
  end

  logic [1:0] q, q_last;
  logic       q_upd, settled;
  logic [0:0] state;
  logic       is_fwd, is_rev, is_bad;

  quad_input_filter #(.DEB_CYCLES(DEB_CYCLES)) u_filt (
    .clock   (clock),
    .reset   (reset),
    .a_in    (a_in),
    .b_in    (b_in),
    .q       (q),
    .q_upd   (q_upd),
    .settled (settled)
  );

  // q_last still holds the pre-update pair while q_upd is high.
  assign is_fwd = (q == FWD_NEXT[q_last]);
  assign is_rev = (q == REV_NEXT[q_last]);
  assign is_bad = &(q ^ q_last);

  always_ff @(posedge clock or negedge reset) begin
    if (!reset) begin
      state  <= INIT;
      q_last <= 2'b00;
      step   <= 1'b0;
      up     <= 1'b0;
      err    <= 1'b0;
    end else begin
      step <= 1'b0;
      err  <= 1'b0;
      if (q_upd) q_last <= q;
      case (state)
        // First accepted pair is a position, not a movement: load silently.
        INIT: if (q_upd || settled) state <= TRACK;
        TRACK: if (q_upd) begin
          if (is_fwd) begin
            step <= 1'b1;
            up   <= 1'b1;
          end else if (is_rev) begin
            step <= 1'b1;
            up   <= 1'b0;
          end else if (is_bad) begin
            err  <= 1'b1;
          end
        end
        default: state <= INIT;
      endcase
    end
  end

`ifdef QUAD_ERR_CNT_EN
  always_ff @(posedge clock or negedge reset) begin
    if (!reset)                    err_count <= '0;
    else if (err && ~&err_count)   err_count <= err_count + 1'b1;
  end
`endif

endmodule

// File: tb/tb_quad_step_decoder.sv
// Directed bench for quad_step_decoder (DEB_CYCLES = 4, ERR_W = 2).
module tb_quad_step_decoder;

  logic clock = 1'b0;
  logic reset = 1'b0;
  logic a_in  = 1'b0;
  logic b_in  = 1'b0;
  logic step, up, err;
`ifdef QUAD_ERR_CNT_EN
  logic [1:0] err_count;
`endif

  int n_chk  = 0;
  int n_fail = 0;

  always #5 clock = ~clock;

  quad_step_decoder #(.DEB_CYCLES(4), .ERR_W(2)) dut (
    .clock     (clock),
    .reset     (reset),
    .a_in      (a_in),
    .b_in      (b_in),
    .step      (step),
    .up        (up),
`ifdef QUAD_ERR_CNT_EN
    .err       (err),
    .err_count (err_count)
`else
    .err       (err)
`endif
  );

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_chk++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  // Drive {a,b} then watch n clocks, sampling 1 time unit after each edge.
  task automatic watch(input logic [1:0] ab, input int n,
                       output int first, output int ns, output int ne);
    a_in  = ab[1];
    b_in  = ab[0];
    first = -1;
    ns    = 0;
    ne    = 0;
    for (int i = 1; i <= n; i++) begin
      @(posedge clock); #1;
      if (step === 1'b1) begin
        ns++;
        if (first < 0) first = i;
      end
      if (err === 1'b1) ne++;
    end
  endtask

  initial begin
    int f, ns, ne, ns2, ne2, tot_e;
    logic [1:0] fwd [4];
    logic [1:0] rev [4];
    fwd = '{2'b01, 2'b11, 2'b10, 2'b00};
    rev = '{2'b10, 2'b11, 2'b01, 2'b00};

    // 1: reset state, then idle 00 -> TRACK silently
    repeat (3) @(posedge clock);
    #1;
    check("rst_step", step, 0);
    check("rst_up",   up,   0);
    check("rst_err",  err,  0);
    reset = 1'b1;
    watch(2'b00, 10, f, ns, ne);
    check("idle_steps", ns, 0);
    check("idle_errs",  ne, 0);
    check("idle_state", dut.state, 1);

    // 2: forward Gray sequence
    for (int k = 0; k < 4; k++) begin
      watch(fwd[k], 8, f, ns, ne);
      check($sformatf("fwd%0d_lat", k),   f,  7);
      check($sformatf("fwd%0d_steps", k), ns, 1);
      check($sformatf("fwd%0d_errs", k),  ne, 0);
      check($sformatf("fwd%0d_up", k),    up, 1);
    end

    // 3: reverse Gray sequence, then idle
    for (int k = 0; k < 4; k++) begin
      watch(rev[k], 8, f, ns, ne);
      check($sformatf("rev%0d_lat", k),   f,  7);
      check($sformatf("rev%0d_steps", k), ns, 1);
      check($sformatf("rev%0d_errs", k),  ne, 0);
      check($sformatf("rev%0d_up", k),    up, 0);
    end
    watch(2'b00, 10, f, ns, ne);
    check("rev_idle_steps", ns, 0);
    check("rev_idle_up",    up, 0);

    // 4: 3-clock glitch on b (pair 01) is filtered out
    watch(2'b01, 3, f, ns, ne);
    watch(2'b00, 10, f, ns2, ne2);
    check("glitch_steps", ns + ns2, 0);
    check("glitch_errs",  ne + ne2, 0);
    check("glitch_q",     dut.u_filt.q, 2'b00);

    // 5: illegal double-phase changes, five of them
    watch(2'b11, 8, f, ns, ne);
    check("bad_lat",   f,  -1);
    check("bad_steps", ns, 0);
    check("bad_errs",  ne, 1);
    check("bad_up",    up, 0);
    tot_e = ne;
    for (int k = 0; k < 4; k++) begin
      watch((k % 2 == 0) ? 2'b00 : 2'b11, 8, f, ns, ne);
      tot_e += ne;
      check($sformatf("bad%0d_steps", k), ns, 0);
    end
    check("bad_total_errs", tot_e, 5);
`ifdef QUAD_ERR_CNT_EN
    check("err_count_sat", err_count, 2'b11);
`endif

    // 6: reset mid-debounce of an 01 edge, release with inputs at 01
    watch(2'b01, 4, f, ns, ne);
    check("pre_rst_steps", ns, 0);
    reset = 1'b0;
    #1;
    check("mid_rst_q",    dut.u_filt.q, 2'b00);
    check("mid_rst_step", step, 0);
    check("mid_rst_up",   up,   0);
`ifdef QUAD_ERR_CNT_EN
    check("mid_rst_err_count", err_count, 2'b00);
`endif
    @(posedge clock); #1;
    reset = 1'b1;
    watch(2'b01, 12, f, ns, ne);
    check("init_load_steps", ns, 0);
    check("init_load_errs",  ne, 0);
    check("init_load_q",     dut.u_filt.q, 2'b01);
    check("init_load_state", dut.state, 1);
    watch(2'b11, 8, f, ns, ne);
    check("post_rst_lat",   f,  7);
    check("post_rst_steps", ns, 1);
    check("post_rst_up",    up, 1);

    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end

endmodule
